// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter client handshake controller.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } arb_client_state_t;

  localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/arb_sync2.sv
// Two-flop synchroniser for a single asynchronous level; both flops clear on rst.
module arb_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/arb_client_if.sv
// Requester-side four-phase req/gnt controller owning the shared resource for one burst.
// Define ARB_CLIENT_GNT_SYNC_EN to pass gnt through a two-flop synchroniser.
module arb_client_if
  import arb_pkg::*;
#(
  parameter int BURST_W        = 8,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               gnt,
  output logic               req,
  output logic               busy,
  output logic               xfer_valid,
  output logic [BURST_W-1:0] beat_idx,
  output logic               done,
  output logic               timeout_err,
  output logic               abort_err
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_client_state_t r_state;
  arb_client_state_t w_next;

  logic               w_gnt_s;
  logic               r_req;
  logic [BURST_W-1:0] r_len;
  logic [BURST_W-1:0] r_beat;
  logic [15:0]        r_wait;
  logic               r_ok;
  logic               w_last_beat;
  logic               w_wait_last;
  logic               w_xfer;
  logic               w_done;
  logic               w_timeout;
  logic               w_abort;

`ifdef ARB_CLIENT_GNT_SYNC_EN
  arb_sync2 u_gnt_sync (
    .clk (clk),
    .rst (rst),
    .d   (gnt),
    .q   (w_gnt_s)
  );
`else
  assign w_gnt_s = gnt;
`endif

  assign w_last_beat = (r_beat == (r_len - BURST_W'(1)));
  assign w_wait_last = (r_wait == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A grant arriving in the same cycle as the timeout takes priority.
  always_comb begin
    w_next    = r_state;
    w_xfer    = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && (burst_len != '0) && !w_gnt_s) w_next = REQ;
      end
      REQ: begin
        if (w_gnt_s) begin
          w_next = XFER;
        end else if (w_wait_last) begin
          w_next    = RELEASE;
          w_timeout = 1'b1;
        end
      end
      XFER: begin
        if (!w_gnt_s) begin
          w_next  = RELEASE;
          w_abort = 1'b1;
        end else begin
          w_xfer = 1'b1;
          if (w_last_beat) w_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!w_gnt_s) begin
          w_next = IDLE;
          w_done = r_ok;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // r_ok remembers whether the burst being released finished all its beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req  <= 1'b0;
      r_len  <= '0;
      r_beat <= '0;
      r_wait <= '0;
      r_ok   <= 1'b0;
    end else begin
      r_req <= (w_next == REQ) || (w_next == XFER);
      case (r_state)
        IDLE: begin
          if (w_next == REQ) begin
            r_len  <= burst_len;
            r_wait <= '0;
            r_ok   <= 1'b0;
          end
        end
        REQ: begin
          r_wait <= r_wait + 16'd1;
          r_beat <= '0;
        end
        XFER: begin
          if (w_next == XFER) r_beat <= r_beat + BURST_W'(1);
          else                r_beat <= '0;
          r_ok <= w_xfer && w_last_beat;
        end
        default: ;
      endcase
    end
  end

  assign req         = r_req;
  assign busy        = (r_state != IDLE);
  assign xfer_valid  = w_xfer;
  assign beat_idx    = r_beat;
  assign done        = w_done;
  assign timeout_err = w_timeout;
  assign abort_err   = w_abort;

endmodule

// File: tb/tb_arb_client_if.sv
// Bench for arb_client_if: directed scenarios plus randomized traffic against a phase-level model.
module tb_arb_client_if;

  localparam int BW  = 8;
  localparam int TMO = 10;
`ifdef ARB_CLIENT_GNT_SYNC_EN
  localparam int SLAT = 2;
`else
  localparam int SLAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [BW-1:0] burst_len;
  logic          gnt;
  logic          req;
  logic          busy;
  logic          xfer_valid;
  logic [BW-1:0] beat_idx;
  logic          done;
  logic          timeout_err;
  logic          abort_err;

  always #5 clk = ~clk;

  arb_client_if #(.BURST_W(BW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .burst_len   (burst_len),
    .gnt         (gnt),
    .req         (req),
    .busy        (busy),
    .xfer_valid  (xfer_valid),
    .beat_idx    (beat_idx),
    .done        (done),
    .timeout_err (timeout_err),
    .abort_err   (abort_err)
  );

  int total = 0;
  int bad   = 0;

  // Observed-event tallies, owned by the compare process.
  int   cyc = 0;
  int   cum_xfer = 0, cum_done = 0, cum_to = 0, cum_ab = 0, cum_req = 0, cum_bsum = 0;
  int   xfer_rise_cyc = 0;
  logic prev_xv = 1'b0;

  // Model: 0 idle, 1 waiting for grant, 2 owning, 3 releasing.
  int m_phase = 0;
  int m_waited = 0, m_left = 0, m_len = 0;
  bit m_ok = 1'b0, m_g1 = 1'b0, m_g2 = 1'b0;
  int m_xfer_cnt = 0, m_done_cnt = 0;

  // Literal expectations queued by the stimulus process.
  string       lit_name[$];
  logic [31:0] lit_act[$];
  logic [31:0] lit_exp[$];
  int          lit_seen = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    int nphase;
    bit gs;
    bit e_req, e_busy, e_xv, e_done, e_to, e_ab;
    int e_beat;
    cyc++;
    while (lit_seen < lit_name.size()) begin
      check(lit_name[lit_seen], lit_act[lit_seen], lit_exp[lit_seen]);
      lit_seen++;
    end
    if (rst) begin
      check("rst_req", 32'(req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_xfer_valid", 32'(xfer_valid), 32'd0);
      check("rst_beat_idx", 32'(beat_idx), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      check("rst_abort_err", 32'(abort_err), 32'd0);
      m_phase = 0;
      m_ok    = 1'b0;
      m_g1    = 1'b0;
      m_g2    = 1'b0;
    end else begin
      gs     = (SLAT != 0) ? m_g2 : gnt;
      nphase = m_phase;
      e_req = 0; e_busy = 0; e_xv = 0; e_done = 0; e_to = 0; e_ab = 0;
      e_beat = 0;
      case (m_phase)
        0: begin
          if (start && burst_len != 0 && !gs) begin
            nphase   = 1;
            m_waited = 0;
            m_len    = int'(burst_len);
          end
        end
        1: begin
          e_req = 1; e_busy = 1;
          if (gs) begin
            nphase = 2;
            m_left = m_len;
          end else if (m_waited + 1 >= TMO) begin
            e_to   = 1;
            nphase = 3;
            m_ok   = 0;
          end else begin
            m_waited++;
          end
        end
        2: begin
          e_req = 1; e_busy = 1;
          if (!gs) begin
            e_ab   = 1;
            nphase = 3;
            m_ok   = 0;
          end else begin
            e_xv   = 1;
            e_beat = m_len - m_left;
            m_left--;
            m_xfer_cnt++;
            if (m_left == 0) begin
              nphase = 3;
              m_ok   = 1;
            end
          end
        end
        default: begin
          e_busy = 1;
          if (!gs) begin
            e_done = m_ok;
            if (m_ok) m_done_cnt++;
            nphase = 0;
          end
        end
      endcase
      check("req", 32'(req), 32'(e_req));
      check("busy", 32'(busy), 32'(e_busy));
      check("xfer_valid", 32'(xfer_valid), 32'(e_xv));
      check("done", 32'(done), 32'(e_done));
      check("timeout_err", 32'(timeout_err), 32'(e_to));
      check("abort_err", 32'(abort_err), 32'(e_ab));
      if (e_xv) check("beat_idx", 32'(beat_idx), 32'(e_beat));
      m_phase = nphase;
      m_g2    = m_g1;
      m_g1    = gnt;
    end
    if (xfer_valid) begin
      cum_xfer++;
      cum_bsum += int'(beat_idx);
      if (!prev_xv) xfer_rise_cyc = cyc;
    end
    if (done)        cum_done++;
    if (timeout_err) cum_to++;
    if (abort_err)   cum_ab++;
    if (req)         cum_req++;
    prev_xv = xfer_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
    lit_name.push_back(nm);
    lit_act.push_back(act);
    lit_exp.push_back(exp);
  endtask

  task automatic wait_req_low(string nm);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!req) return;
    end
    lit({nm, "_wait_req_low_expired"}, 32'd0, 32'd1);
  endtask

  task automatic wait_beat(string nm, int b);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (xfer_valid && int'(beat_idx) == b) return;
    end
    lit({nm, "_wait_beat_expired"}, 32'd0, 32'd1);
  endtask

  initial begin
    int s_xfer, s_done, s_to, s_ab, s_req, s_bsum, s_mx, s_md, t0;
    rst = 1'b1; start = 1'b0; gnt = 1'b0; burst_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic burst of 4, grant 3 cycles after req, released 2 cycles after req falls.
    tick();
    s_xfer = cum_xfer; s_done = cum_done; s_bsum = cum_bsum; s_mx = m_xfer_cnt; s_md = m_done_cnt;
    s_to = cum_to; s_ab = cum_ab;
    start = 1'b1; burst_len = 8'd4; t0 = cyc + 1;
    tick(); start = 1'b0; burst_len = 8'hA5;
    tick(); tick(); tick(); gnt = 1'b1;
    wait_req_low("basic");
    tick(); tick(); gnt = 1'b0;
    repeat (6) tick();
    lit("basic_first_xfer_latency", 32'(xfer_rise_cyc - t0), 32'(5 + SLAT));
    lit("basic_beats", 32'(cum_xfer - s_xfer), 32'd4);
    lit("basic_beat_sum", 32'(cum_bsum - s_bsum), 32'd6);
    lit("basic_done", 32'(cum_done - s_done), 32'd1);
    lit("basic_no_err", 32'((cum_to - s_to) + (cum_ab - s_ab)), 32'd0);
    lit("model_basic_beats", 32'(m_xfer_cnt - s_mx), 32'd4);
    lit("model_basic_done", 32'(m_done_cnt - s_md), 32'd1);

    // Timeout with gnt held low.
    tick();
    s_xfer = cum_xfer; s_done = cum_done; s_to = cum_to; s_req = cum_req;
    start = 1'b1; burst_len = 8'd2;
    tick(); start = 1'b0;
    repeat (15) tick();
    lit("timeout_req_cycles", 32'(cum_req - s_req), 32'(TMO));
    lit("timeout_pulses", 32'(cum_to - s_to), 32'd1);
    lit("timeout_no_xfer", 32'(cum_xfer - s_xfer), 32'd0);
    lit("timeout_no_done", 32'(cum_done - s_done), 32'd0);
    lit("timeout_busy_end", 32'(busy), 32'd0);

    // Grant revoked after beat 2 of an 8-beat burst.
    s_xfer = cum_xfer; s_done = cum_done; s_ab = cum_ab;
    start = 1'b1; burst_len = 8'd8;
    tick(); start = 1'b0;
    tick(); gnt = 1'b1;
    wait_beat("abort", 2);
    tick(); gnt = 1'b0;
    repeat (8) tick();
    lit("abort_pulses", 32'(cum_ab - s_ab), 32'd1);
    lit("abort_no_done", 32'(cum_done - s_done), 32'd0);
    lit("abort_beats", 32'(cum_xfer - s_xfer), 32'(3 + SLAT));
    lit("abort_idle", 32'({busy, req}), 32'd0);

    // Zero-length start, then a start issued mid-transfer.
    s_req = cum_req;
    start = 1'b1; burst_len = 8'd0;
    tick(); start = 1'b0;
    repeat (4) tick();
    lit("zero_len_no_req", 32'(cum_req - s_req), 32'd0);
    lit("zero_len_not_busy", 32'(busy), 32'd0);
    s_xfer = cum_xfer; s_done = cum_done;
    start = 1'b1; burst_len = 8'd3;
    tick(); start = 1'b0;
    tick(); gnt = 1'b1;
    wait_beat("busy_start", 0);
    start = 1'b1; burst_len = 8'd5;
    tick(); start = 1'b0;
    wait_req_low("busy_start");
    tick(); gnt = 1'b0;
    repeat (6) tick();
    lit("busy_start_done", 32'(cum_done - s_done), 32'd1);
    lit("busy_start_beats", 32'(cum_xfer - s_xfer), 32'd3);
    s_req = cum_req;
    repeat (6) tick();
    lit("busy_start_not_queued", 32'(cum_req - s_req), 32'd0);

    // Asynchronous reset between edges at beat 1.
    start = 1'b1; burst_len = 8'd6;
    tick(); start = 1'b0; gnt = 1'b1;
    wait_beat("rst_mid", 1);
    #2 rst = 1'b1;
    #1;
    lit("rst_mid_req", 32'(req), 32'd0);
    lit("rst_mid_xfer_valid", 32'(xfer_valid), 32'd0);
    lit("rst_mid_busy", 32'(busy), 32'd0);
    lit("rst_mid_beat_idx", 32'(beat_idx), 32'd0);
    tick(); rst = 1'b0; gnt = 1'b0;
    tick();
    s_xfer = cum_xfer; s_done = cum_done;
    start = 1'b1; burst_len = 8'd2;
    tick(); start = 1'b0;
    tick(); gnt = 1'b1;
    wait_req_low("after_rst");
    tick(); gnt = 1'b0;
    repeat (6) tick();
    lit("after_rst_done", 32'(cum_done - s_done), 32'd1);
    lit("after_rst_beats", 32'(cum_xfer - s_xfer), 32'd2);

    // Randomized traffic: random starts, lengths, grant wander and rare resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst       = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 2) == 0);
      burst_len = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 4) == 0) gnt = ~gnt;
    end
    rst = 1'b0; start = 1'b0; gnt = 1'b0;
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
